// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: instruction-RAM / decoder side signals of the CPU control sequencer.
// Optional macro CPU_SEQ_IRQ_EN adds the irq / irq_ack pair.
// master = sequencer side, slave = RAM/decoder side.
interface cpu_sequencer_if #(
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned STATUS_W = 8,
    parameter int unsigned COND_W   = 4,
    parameter int unsigned MAX_EXEC = 4
);
    localparam int unsigned IDX_W = (MAX_EXEC > 1) ? $clog2(MAX_EXEC) : 1;

    logic [INSTR_W-1:0]  instruction;
    logic                mem_ready;
    logic [COND_W-1:0]   cond_field;
    logic [IDX_W-1:0]    exec_cycles;
    logic [STATUS_W-1:0] status_reg;
    logic                stop_req;
    logic                stack_overflow;
    logic                set_jump;
    logic                resume;
    logic [INSTR_W-1:0]  ir;
    logic                state_fetch;
    logic                state_exec;
    logic [IDX_W-1:0]    exec_idx;
    logic                cond_pass;
    logic                last_exec;
    logic                jump;
    logic                halted;
`ifdef CPU_SEQ_IRQ_EN
    logic                irq;
    logic                irq_ack;

    modport master (
        input  instruction, mem_ready, cond_field, exec_cycles, status_reg,
               stop_req, stack_overflow, set_jump, resume, irq,
        output ir, state_fetch, state_exec, exec_idx, cond_pass, last_exec,
               jump, halted, irq_ack
    );
    modport slave (
        output instruction, mem_ready, cond_field, exec_cycles, status_reg,
               stop_req, stack_overflow, set_jump, resume, irq,
        input  ir, state_fetch, state_exec, exec_idx, cond_pass, last_exec,
               jump, halted, irq_ack
    );
`else
    modport master (
        input  instruction, mem_ready, cond_field, exec_cycles, status_reg,
               stop_req, stack_overflow, set_jump, resume,
        output ir, state_fetch, state_exec, exec_idx, cond_pass, last_exec,
               jump, halted
    );
    modport slave (
        output instruction, mem_ready, cond_field, exec_cycles, status_reg,
               stop_req, stack_overflow, set_jump, resume,
        input  ir, state_fetch, state_exec, exec_idx, cond_pass, last_exec,
               jump, halted
    );
`endif
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute control FSM sitting between instruction RAM and the decoder.
// Latches IR, evaluates the condition field once per instruction, counts execute cycles,
// handles memory wait states, halt/resume and the pending-jump flag.
// Optional macro CPU_SEQ_IRQ_EN adds a one-cycle IRQ state between instructions.
module cpu_sequencer #(
    parameter int unsigned INSTR_W     = 16,
    parameter int unsigned STATUS_W    = 8,
    parameter int unsigned COND_W      = 4,
    parameter int unsigned ALWAYS_CODE = 6,
    parameter int unsigned MAX_EXEC    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    cpu_sequencer_if.master bus
);
    localparam int unsigned     IDX_W   = (MAX_EXEC > 1) ? $clog2(MAX_EXEC) : 1;
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_EXEC - 1);

`ifdef CPU_SEQ_IRQ_EN
    typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_HALT = 2'd2, S_IRQ = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_HALT = 2'd2} state_t;
`endif

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [IDX_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               cond_q, cond_d;
    logic               jump_q, jump_d;

    logic [COND_W-2:0]  sel;
    logic               inv;
    logic               sel_valid;
    logic               sel_bit;
    logic               cond_eval;
    logic               halt_cond;
    logic               at_last;

    assign sel       = bus.cond_field[COND_W-2:0];
    assign inv       = bus.cond_field[COND_W-1];
    assign halt_cond = bus.stop_req | (bus.stack_overflow & cond_q);
    assign at_last   = (idx_q == count_q);

    // Condition evaluation: always-code and out-of-range selects both read as true.
    always_comb begin
        sel_valid = 1'b0;
        sel_bit   = 1'b0;
        for (int unsigned i = 0; i < STATUS_W; i++) begin
            if (32'(sel) == i) begin
                sel_valid = 1'b1;
                sel_bit   = bus.status_reg[i] ^ inv;
            end
        end
        cond_eval = 1'b1;
        if (32'(sel) != ALWAYS_CODE && sel_valid) begin
            cond_eval = sel_bit;
        end
    end

    // Next-state logic; halt is checked before wait states and completion.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        count_d = count_q;
        idx_d   = idx_q;
        cond_d  = cond_q;
        jump_d  = jump_q;
        case (state_q)
            S_FETCH: begin
                if (bus.set_jump) begin
                    jump_d = 1'b1;
                end
                if (bus.mem_ready) begin
                    ir_d    = bus.instruction;
                    count_d = (bus.exec_cycles > MAX_IDX) ? MAX_IDX : bus.exec_cycles;
                    cond_d  = cond_eval;
                    idx_d   = '0;
                    jump_d  = bus.set_jump;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.set_jump) begin
                    jump_d = 1'b1;
                end
                if (halt_cond) begin
                    state_d = S_HALT;
                end else if (bus.mem_ready) begin
                    if (at_last) begin
`ifdef CPU_SEQ_IRQ_EN
                        state_d = (bus.irq && bus.status_reg[STATUS_W-1]) ? S_IRQ : S_FETCH;
`else
                        state_d = S_FETCH;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_HALT: begin
                if (bus.resume) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                end
            end
`ifdef CPU_SEQ_IRQ_EN
            S_IRQ: begin
                jump_d  = 1'b1;
                state_d = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            count_q <= '0;
            idx_q   <= '0;
            cond_q  <= 1'b0;
            jump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            cond_q  <= cond_d;
            jump_q  <= jump_d;
        end
    end

    assign bus.ir          = ir_q;
    assign bus.state_fetch = (state_q == S_FETCH);
    assign bus.state_exec  = (state_q == S_EXEC);
    assign bus.exec_idx    = idx_q;
    assign bus.cond_pass   = cond_q;
    assign bus.last_exec   = (state_q == S_EXEC) & bus.mem_ready & at_last;
    assign bus.jump        = jump_q;
    assign bus.halted      = (state_q == S_HALT);
`ifdef CPU_SEQ_IRQ_EN
    assign bus.irq_ack     = (state_q == S_IRQ);
`endif
endmodule
